bbuf_drain: RTL and testbench
=============================

# bbuf_drain

Read-back engine for the bias/array buffer family: on command, reads `num_rows` consecutive wide rows (ARRAY_M lanes × DATA_WIDTH) from a lane-banked buffer and streams each row out as MEM_DATA_WIDTH memory-write beats with a valid/ready handshake. It is the inverse of the buffer's memory-write path. Beat `b` of row `r` is written to memory address `{r, b}`, and lane `m` travels in beat `m/GROUP_SIZE` at slot `m%GROUP_SIZE`. It sits between a buffer's wide read port and the memory write interface.

## Interface
- MEM_DATA_WIDTH, 64, memory beat width
- ARRAY_M, 4, lanes per buffer row
- DATA_WIDTH, 32, bits per lane
- BUF_ADDR_WIDTH, 10, buffer row address width
- GROUP_SIZE, MEM_DATA_WIDTH/DATA_WIDTH, lanes per beat; ARRAY_M must be a multiple of it
- NUM_BEATS, ARRAY_M/GROUP_SIZE, beats per row
- BUF_ID_W, $clog2(NUM_BEATS), beat-index bits (0 when NUM_BEATS==1)
- MEM_ADDR_WIDTH, BUF_ADDR_WIDTH+BUF_ID_W, memory write address width
- BUF_DATA_WIDTH, ARRAY_M*DATA_WIDTH, buffer row width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  command strobe; accepted only in IDLE
- base_addr  in  BUF_ADDR_WIDTH  first row
- num_rows  in  BUF_ADDR_WIDTH+1  row count (0 allowed)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- buf_read_req  out  1  buffer read strobe
- buf_read_addr  out  BUF_ADDR_WIDTH  buffer read row
- buf_read_data  in  BUF_DATA_WIDTH  row data, valid exactly 1 cycle after buf_read_req
- mem_write_req  out  1  beat valid
- mem_write_addr  out  MEM_ADDR_WIDTH  {row, beat}
- mem_write_data  out  MEM_DATA_WIDTH  beat payload
- mem_write_ready  in  1  sink accepts beat when req&&ready

## Operation
- **States:** IDLE, RD, LOAD, SEND, DONE.
- **IDLE:**
  - On start: latch base_addr into row pointer and num_rows into remaining count, then go to RD.
  - If num_rows==0: go directly to DONE; no buffer read or memory write is issued.
- **RD:** buf_read_req=1 and buf_read_addr=row pointer for exactly one cycle → LOAD.
- **LOAD:** capture buf_read_data into an internal holding register, clear beat index → SEND.
- **SEND:**
  - mem_write_req=1.
  - mem_write_addr = {row pointer, beat index}. When BUF_ID_W==0 it is the row pointer alone.
  - mem_write_data = holding[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]; lower lane in lower bits.
  - On req&&ready: if the beat is not last, increment the beat index; if it is the last beat (NUM_BEATS-1), decrement remaining and increment the row pointer. Then go to RD if remaining is still nonzero, else DONE.
- **DONE:** done=1 and busy=1 for one cycle → IDLE.
- **Row pointer** wraps modulo 2^BUF_ADDR_WIDTH (e.g. base 1023, 2 rows → rows 1023, 0).
- **start outside IDLE** is ignored; no queuing.
- **Reset mid-operation:** state returns to IDLE immediately. Any in-flight beat is dropped and no done pulse is issued.

## Timing
- **Reset values:** busy, done, buf_read_req, mem_write_req = 0; buf_read_addr, mem_write_addr, mem_write_data = 0.
- All outputs are registered or decoded from registered state; no combinational path from mem_write_ready to any output.
- **Start latency:** start sampled at edge 0 → RD (buf_read_req) in cycle 1 → LOAD in cycle 2 → first mem_write_req in cycle 3.
- **Throughput:** per row, 2 + NUM_BEATS cycles with ready held high.
- **Stall:** while mem_write_req=1 and ready=0, mem_write_addr and mem_write_data hold stable and req stays high.
- **Completion:** done asserts the cycle after the final beat handshake; busy drops the cycle after done.
- Zero-row command: done in cycle 1 after start.

## Test plan
- **Single row, defaults (NUM_BEATS=2), ready=1:** base 5, rows 1, lanes {L3,L2,L1,L0} = {D,C,B,A}.
  - Read of addr 5 in cycle 1.
  - Beats in cycles 3–4: addr 10 with {B,A}, then addr 11 with {D,C}.
  - done in cycle 5.
- **Multi-row with wrap:** base 1023, rows 3.
  - Reads of addrs 1023, 0, 1.
  - Memory addrs 2046, 2047, 0, 1, 2, 3.
  - Exactly 6 beats and one done.
- **Backpressure:** ready low for 4 cycles during beat 1.
  - addr and data hold unchanged throughout.
  - No duplicate or lost beat.
  - done delayed by exactly 4 cycles.
- **num_rows=0:** no buf_read_req, no mem_write_req; done pulses in cycle 1 and busy returns to 0.
- **Start while busy plus reset:**
  - A second start mid-transfer is ignored; beat count matches the first command only.
  - Asserting reset during SEND forces all outputs to 0 asynchronously.
  - A fresh start after reset runs correctly.
- **Parameter sweep:** ARRAY_M=2 (NUM_BEATS=1, BUF_ID_W=0) gives mem_write_addr equal to the row address, one beat per row, 3 cycles per row.

Source files
------------

// File: rtl/bbuf_drain.sv
// Buffer read-back engine: reads num_rows wide rows from a lane-banked buffer
// and streams each row out as MEM_DATA_WIDTH memory-write beats addressed {row, beat}.
module bbuf_drain #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int ARRAY_M        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BUF_ADDR_WIDTH = 10,
    parameter int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
    parameter int NUM_BEATS      = ARRAY_M / GROUP_SIZE,
    parameter int BUF_ID_W       = $clog2(NUM_BEATS),
    parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
    parameter int BUF_DATA_WIDTH = ARRAY_M * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BUF_ADDR_WIDTH-1:0] base_addr,
    input  logic [BUF_ADDR_WIDTH:0]   num_rows,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_read_req,
    output logic [BUF_ADDR_WIDTH-1:0] buf_read_addr,
    input  logic [BUF_DATA_WIDTH-1:0] buf_read_data,
    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
    input  logic                      mem_write_ready
);
    // state  | meaning
    // IDLE   | waiting for start
    // RD     | buffer read strobe for the current row
    // LOAD   | capture returned row into the holding register
    // SEND   | present beats to memory until the last one is accepted
    // DONE   | one-cycle completion pulse

    localparam int BEAT_W = (BUF_ID_W > 0) ? BUF_ID_W : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LOAD, S_SEND, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [BUF_ADDR_WIDTH-1:0] row_q, row_d;
    logic [BUF_ADDR_WIDTH:0]   rem_q, rem_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BUF_DATA_WIDTH-1:0] hold_q, hold_d;

    logic [MEM_DATA_WIDTH-1:0] beat_data;
    logic [MEM_ADDR_WIDTH-1:0] send_addr;
    logic                      last_beat;

    assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));

    generate
        if (NUM_BEATS > 1) begin : g_multi
            logic [MEM_DATA_WIDTH-1:0] beats [NUM_BEATS];
            for (genvar b = 0; b < NUM_BEATS; b++) begin : g_slice
                assign beats[b] = hold_q[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            end
            assign beat_data = beats[beat_q];
            assign send_addr = {row_q, beat_q};
        end else begin : g_single
            assign beat_data = hold_q[MEM_DATA_WIDTH-1:0];
            assign send_addr = row_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = base_addr;
                    rem_d   = num_rows;
                    state_d = (num_rows == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: state_d = S_LOAD;
            S_LOAD: begin
                hold_d  = buf_read_data;
                beat_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (mem_write_ready) begin
                    if (!last_beat) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else begin
                        // row pointer wraps naturally at 2^BUF_ADDR_WIDTH
                        rem_d   = rem_q - (BUF_ADDR_WIDTH+1)'(1);
                        row_d   = row_q + BUF_ADDR_WIDTH'(1);
                        state_d = (rem_q == (BUF_ADDR_WIDTH+1)'(1)) ? S_DONE : S_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decode registered state only; address/data are zeroed outside their state
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        buf_read_req   = 1'b0;
        buf_read_addr  = '0;
        mem_write_req  = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        case (state_q)
            S_RD: begin
                buf_read_req  = 1'b1;
                buf_read_addr = row_q;
            end
            S_SEND: begin
                mem_write_req  = 1'b1;
                mem_write_addr = send_addr;
                mem_write_data = beat_data;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bbuf_drain.sv
// Directed bench for bbuf_drain: cycle-exact vector table plus sequences for
// row wrap, reset abort and the single-beat (ARRAY_M=2) configuration.
module tb_bbuf_drain;
    logic         clk = 1'b0;
    logic         reset;
    logic         start, mem_write_ready;
    logic [9:0]   base_addr;
    logic [10:0]  num_rows;
    logic         busy, done, buf_read_req, mem_write_req;
    logic [9:0]   buf_read_addr;
    logic [127:0] buf_read_data;
    logic [10:0]  mem_write_addr;
    logic [63:0]  mem_write_data;

    logic         s_start, s_busy, s_done, s_rreq, s_wreq, s_ready;
    logic [9:0]   s_base, s_raddr, s_waddr;
    logic [10:0]  s_rows;
    logic [63:0]  s_rdata, s_wdata;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bbuf_drain u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done),
        .buf_read_req(buf_read_req), .buf_read_addr(buf_read_addr),
        .buf_read_data(buf_read_data), .mem_write_req(mem_write_req),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready)
    );

    bbuf_drain #(.ARRAY_M(2)) u_dut_m2 (
        .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base),
        .num_rows(s_rows), .busy(s_busy), .done(s_done),
        .buf_read_req(s_rreq), .buf_read_addr(s_raddr),
        .buf_read_data(s_rdata), .mem_write_req(s_wreq),
        .mem_write_addr(s_waddr), .mem_write_data(s_wdata),
        .mem_write_ready(s_ready)
    );

    function automatic logic [31:0] lane(int r, int m);
        return 32'hA500_0000 | 32'(r << 8) | 32'(m);
    endfunction

    function automatic logic [63:0] beat(int r, int b);
        return {lane(r, 2*b+1), lane(r, 2*b)};
    endfunction

    // buffer models: row data valid only in the cycle after the read strobe
    always @(posedge clk) begin
        if (buf_read_req) buf_read_data <= {beat(int'(buf_read_addr), 1), beat(int'(buf_read_addr), 0)};
        else              buf_read_data <= {4{32'hDEAD_BEEF}};
        if (s_rreq) s_rdata <= beat(int'(s_raddr), 0);
        else        s_rdata <= {2{32'hDEAD_BEEF}};
    end

    int          rd_q[$], wa_q[$], s_wa_q[$];
    logic [63:0] wd_q[$], s_wd_q[$];
    int          done_cnt, s_done_cnt;

    always @(negedge clk) begin
        if (!reset) begin
            if (buf_read_req) rd_q.push_back(int'(buf_read_addr));
            if (mem_write_req && mem_write_ready) begin
                wa_q.push_back(int'(mem_write_addr));
                wd_q.push_back(mem_write_data);
            end
            if (done) done_cnt++;
            if (s_wreq && s_ready) begin
                s_wa_q.push_back(int'(s_waddr));
                s_wd_q.push_back(s_wdata);
            end
            if (s_done) s_done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},  busy, 0);
        chk({tag, ".done"},  done, 0);
        chk({tag, ".rreq"},  buf_read_req, 0);
        chk({tag, ".raddr"}, buf_read_addr, 0);
        chk({tag, ".wreq"},  mem_write_req, 0);
        chk({tag, ".waddr"}, mem_write_addr, 0);
        chk({tag, ".wdata"}, mem_write_data, 0);
    endtask

    typedef struct {
        logic        start;
        logic [9:0]  base;
        logic [10:0] rows;
        logic        ready;
        logic        busy, done, rreq;
        logic [9:0]  raddr;
        logic        wreq;
        logic [10:0] waddr;
        logic [63:0] wdata;
    } vec_t;

    function automatic vec_t mk(logic st, int b, int r, logic rdy, logic bz, logic dn,
                                logic rq, int ra, logic wq, int wa, logic [63:0] wd);
        vec_t v;
        v.start = st; v.base = 10'(b); v.rows = 11'(r); v.ready = rdy;
        v.busy = bz; v.done = dn; v.rreq = rq; v.raddr = 10'(ra);
        v.wreq = wq; v.waddr = 11'(wa); v.wdata = wd;
        return v;
    endfunction

    // start a command on the main DUT and return the cycle done was seen in
    task automatic run_main(input int b, input int r, output int cyc);
        base_addr = 10'(b); num_rows = 11'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    vec_t vecs[$];
    int   cyc;

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; mem_write_ready = 1'b1;
        s_start = 1'b0; s_base = '0; s_rows = '0; s_ready = 1'b1;
        done_cnt = 0; s_done_cnt = 0;

        // single row, base 5
        vecs.push_back(mk(1, 5, 1, 1,  1, 0, 1, 5,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0,  1, 10, beat(5, 0)));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0,  1, 11, beat(5, 1)));
        vecs.push_back(mk(0, 0, 0, 1,  1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
        // zero rows
        vecs.push_back(mk(1, 9, 0, 1,  1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
        // base 7, second start ignored, ready low 4 cycles on first beat
        vecs.push_back(mk(1, 7, 1, 0,  1, 0, 1, 7,  0, 0, 0));
        vecs.push_back(mk(1, 9, 2, 0,  1, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 9, 2, 0,  1, 0, 0, 0,  1, 14, beat(7, 0)));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0,  1, 14, beat(7, 0)));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0,  1, 15, beat(7, 1)));
        vecs.push_back(mk(0, 0, 0, 1,  1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset.m2_busy", s_busy, 0);
        chk("reset.m2_wreq", s_wreq, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            start = vecs[i].start; base_addr = vecs[i].base;
            num_rows = vecs[i].rows; mem_write_ready = vecs[i].ready;
            @(posedge clk); #1;
            chk($sformatf("v%0d.busy", i),  busy,           vecs[i].busy);
            chk($sformatf("v%0d.done", i),  done,           vecs[i].done);
            chk($sformatf("v%0d.rreq", i),  buf_read_req,   vecs[i].rreq);
            chk($sformatf("v%0d.raddr", i), buf_read_addr,  vecs[i].raddr);
            chk($sformatf("v%0d.wreq", i),  mem_write_req,  vecs[i].wreq);
            chk($sformatf("v%0d.waddr", i), mem_write_addr, vecs[i].waddr);
            chk($sformatf("v%0d.wdata", i), mem_write_data, vecs[i].wdata);
        end
        start = 1'b0; mem_write_ready = 1'b1;

        // three rows wrapping past the top of the row space
        rd_q.delete(); wa_q.delete(); wd_q.delete(); done_cnt = 0;
        run_main(1023, 3, cyc);
        chk("wrap.done_cycle", cyc, 13);
        @(posedge clk); #1;
        chk("wrap.busy_after", busy, 0);
        chk("wrap.reads", rd_q.size(), 3);
        chk("wrap.beats", wa_q.size(), 6);
        chk("wrap.dones", done_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            int r;
            r = (1023 + i) % 1024;
            if (i < rd_q.size()) chk($sformatf("wrap.rd%0d", i), rd_q[i], r);
            for (int b = 0; b < 2; b++) begin
                if (2*i+b < wa_q.size()) begin
                    chk($sformatf("wrap.wa%0d", 2*i+b), wa_q[2*i+b], (r*2 + b) % 2048);
                    chk($sformatf("wrap.wd%0d", 2*i+b), wd_q[2*i+b], beat(r, b));
                end
            end
        end

        // reset during SEND aborts without a done pulse
        done_cnt = 0;
        base_addr = 10'd2; num_rows = 11'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!mem_write_req && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort.send_cycle", cyc, 3);
        #3 reset = 1'b1;
        #1;
        chk_idle_outputs("abort.async");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("abort.after");
        chk("abort.dones", done_cnt, 0);

        rd_q.delete(); wa_q.delete(); wd_q.delete(); done_cnt = 0;
        run_main(3, 1, cyc);
        chk("restart.done_cycle", cyc, 5);
        @(posedge clk); #1;
        chk("restart.beats", wa_q.size(), 2);
        chk("restart.dones", done_cnt, 1);
        if (wa_q.size() == 2) begin
            chk("restart.wa0", wa_q[0], 6);
            chk("restart.wa1", wa_q[1], 7);
            chk("restart.wd0", wd_q[0], beat(3, 0));
            chk("restart.wd1", wd_q[1], beat(3, 1));
        end

        // ARRAY_M=2: one beat per row, address equals row
        s_wa_q.delete(); s_wd_q.delete(); s_done_cnt = 0;
        s_base = 10'd1022; s_rows = 11'd3; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("m2.done_cycle", cyc, 10);
        @(posedge clk); #1;
        chk("m2.busy_after", s_busy, 0);
        chk("m2.beats", s_wa_q.size(), 3);
        chk("m2.dones", s_done_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < s_wa_q.size()) begin
                chk($sformatf("m2.wa%0d", i), s_wa_q[i], (1022 + i) % 1024);
                chk($sformatf("m2.wd%0d", i), s_wd_q[i], beat((1022 + i) % 1024, 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
